// File: rtl/text_render_seq.sv
`timescale 1ns/1ps
// text_render_seq
//   Buffers one line of glyph codes, then scans it out pixel by pixel through
//   an external combinational glyph ROM. Scan order is row-major: the 8
//   columns of a character, then the next character, then the next row.
//   The line is done after 8 rows, which is 64 pixels per stored character.
//
// Parameters
//   MAX_CHARS  line-buffer depth in characters (power of two, 2..32)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous abort back to IDLE
//   load_valid/ready      character load handshake
//   load_char, load_last  glyph code and final-character marker
//   rom_char/row/col      glyph-ROM address (0 outside RENDER)
//   rom_dot               ROM pixel for the current address (combinational)
//   px_valid/ready        pixel output handshake
//   px_dot                pixel value
//   px_eol, px_eof        last pixel of a scan row / of the whole line
//   busy                  high while loading or rendering
module text_render_seq #(
    parameter int unsigned MAX_CHARS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [4:0] load_char,
    input  logic       load_last,
    output logic [4:0] rom_char,
    output logic [2:0] rom_row,
    output logic [2:0] rom_col,
    input  logic       rom_dot,
    output logic       px_valid,
    input  logic       px_ready,
    output logic       px_dot,
    output logic       px_eol,
    output logic       px_eof,
    output logic       busy
);

    localparam int unsigned PW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RENDER} state_t;

    state_t        state_q, state_d;
    logic [4:0]    line_buf [MAX_CHARS];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] length;
    logic [PW-1:0] ci;
    logic [2:0]    row;
    logic [2:0]    col;

    logic load_hs, px_hs;
    logic last_col, last_ci, at_eol, at_eof;
    logic wr_last;

    // wr_ptr is always 0 in IDLE, so IDLE and LOAD share one write path.
    assign load_hs  = load_valid && load_ready;
    assign px_hs    = px_valid && px_ready;
    assign last_col = (col == 3'd7);
    assign last_ci  = (LW'(ci) == length - LW'(1));
    assign at_eol   = last_col && last_ci;
    assign at_eof   = at_eol && (row == 3'd7);
    // The write into the final slot ends the line even without load_last.
    assign wr_last  = load_last || (wr_ptr == LW'(MAX_CHARS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b1;
        px_valid   = 1'b0;
        px_dot     = 1'b0;
        px_eol     = 1'b0;
        px_eof     = 1'b0;
        rom_char   = '0;
        rom_row    = '0;
        rom_col    = '0;
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE, LOAD: begin
                if (load_hs) begin
                    state_d = wr_last ? RENDER : LOAD;
                end
            end
            RENDER: begin
                load_ready = 1'b0;
                px_valid   = 1'b1;
                rom_char   = line_buf[ci];
                rom_row    = row;
                rom_col    = col;
                px_dot     = rom_dot;
                px_eol     = at_eol;
                px_eof     = at_eof;
                if (px_hs && at_eof) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            length <= '0;
            ci     <= '0;
            row    <= '0;
            col    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            ci     <= '0;
            row    <= '0;
            col    <= '0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (load_hs) begin
                        if (wr_last) begin
                            length <= wr_ptr + LW'(1);
                            wr_ptr <= '0;
                            ci     <= '0;
                            row    <= '0;
                            col    <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + LW'(1);
                        end
                    end
                end
                RENDER: begin
                    if (px_hs) begin
                        if (!last_col) begin
                            col <= col + 3'd1;
                        end else begin
                            col <= '0;
                            if (last_ci) begin
                                ci  <= '0;
                                // Wraps to 0 on the final pixel of the line.
                                row <= row + 3'd1;
                            end else begin
                                ci <= ci + PW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; its contents are only read after a load.
    always_ff @(posedge clk) begin
        if (!clear && load_hs) begin
            line_buf[wr_ptr[PW-1:0]] <= load_char;
        end
    end

endmodule

// File: tb/tb_text_render_seq.sv
`timescale 1ns/1ps
module tb_text_render_seq;

    localparam int unsigned MC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_last = 1'b0;
    logic [4:0] load_char = '0;
    logic       px_ready = 1'b0;
    logic       rom_dot;
    logic       load_ready, px_valid, px_dot, px_eol, px_eof, busy;
    logic [4:0] rom_char;
    logic [2:0] rom_row, rom_col;
    logic [12:0] out_vec;

    int checks = 0;
    int failures = 0;
    int line_cnt = 0;
    bit rdy_rand = 1'b0;
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    text_render_seq #(.MAX_CHARS(MC)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_char(load_char), .load_last(load_last),
        .rom_char(rom_char), .rom_row(rom_row), .rom_col(rom_col),
        .rom_dot(rom_dot),
        .px_valid(px_valid), .px_ready(px_ready), .px_dot(px_dot),
        .px_eol(px_eol), .px_eof(px_eof), .busy(busy)
    );

    // Glyph ROM contents; char 1 row 0 is a single dot at column 3.
    function automatic logic [7:0] glyph_row(input logic [4:0] c, input logic [2:0] r);
        int v;
        if (c == 5'd1 && r == 3'd0) return 8'h08;
        v = (int'(c) * 53 + int'(r) * 97 + int'(c) * int'(r)) ^ 8'h5a;
        return v[7:0];
    endfunction

    function automatic logic glyph_bit(input logic [4:0] c, input logic [2:0] r,
                                       input logic [2:0] col);
        logic [7:0] g;
        g = glyph_row(c, r);
        return g[col];
    endfunction

    assign rom_dot = glyph_bit(rom_char, rom_row, rom_col);
    assign out_vec = {rom_char, rom_row, rom_col, px_dot, px_eol, px_eof};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: whole line in scan order, 64 pixels per character.
    task automatic push_line(input logic [4:0] chars[$], input int len);
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < len; i++)
                for (int c = 0; c < 8; c++) begin
                    logic eol, eof;
                    eol = (i == len - 1) && (c == 7);
                    eof = eol && (r == 7);
                    exp_q.push_back({chars[i], 3'(r), 3'(c),
                                     glyph_bit(chars[i], 3'(r), 3'(c)), eol, eof});
                end
    endtask

    task automatic load_line(input logic [4:0] chars[$], input bit mark_last);
        int n;
        int len;
        n   = chars.size();
        len = (n > int'(MC)) ? int'(MC) : n;
        push_line(chars, len);
        line_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            load_valid = 1'b1;
            load_char  = chars[i];
            load_last  = mark_last && (i == n - 1);
            if (i >= int'(MC)) begin
                @(negedge clk);
                check("load_ready_blocked", 32'(load_ready), 0);
            end
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int npix);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, 32'(exp_q.size() == 0 && !busy), 1);
        check({name, "_npix"}, 32'(line_cnt), 32'(npix));
    endtask

    task automatic rand_chars(output logic [4:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(5'($urandom_range(0, 30)));
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            px_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops and compares on each accepted pixel, checks hold-while-stalled.
    initial begin
        logic        prev_stall;
        logic [12:0] prev_vec;
        logic        chk_idle;
        logic [12:0] e;
        prev_stall = 1'b0;
        prev_vec   = '0;
        chk_idle   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                chk_idle   = 1'b0;
                continue;
            end
            if (chk_idle) begin
                check("idle_after_eof", 32'({busy, px_valid, load_ready}), 32'b001);
                chk_idle = 1'b0;
            end
            if (prev_stall)
                check("stall_hold", 32'({px_valid, out_vec}), 32'({1'b1, prev_vec}));
            if (px_valid && px_ready && !clear) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_px", 32'(px_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("px%0d", line_cnt), 32'(out_vec), 32'(e));
                    if (e[0]) chk_idle = 1'b1;
                end
                line_cnt++;
            end
            prev_stall = px_valid && !px_ready && !clear;
            prev_vec   = out_vec;
        end
    end

    initial begin
        logic [4:0] cq[$];
        int k;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_load_ready", 32'(load_ready), 1);
        check("rst_px_flags", 32'({px_valid, px_eol, px_eof, busy, px_dot}), 0);
        check("rst_rom", 32'({rom_char, rom_row, rom_col}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 32'({load_ready, busy, px_valid}), 32'b100);

        // Single character, last on first load.
        rdy_rand = 1'b0;
        cq.delete(); cq.push_back(5'd1);
        load_line(cq, 1'b1);
        wait_done("one_char", 64);

        // Three characters.
        cq.delete(); cq.push_back(5'd2); cq.push_back(5'd5); cq.push_back(5'd10);
        load_line(cq, 1'b1);
        wait_done("three_char", 192);

        // Overflow: MC+1 characters without load_last.
        rand_chars(cq, int'(MC) + 1);
        load_line(cq, 1'b0);
        wait_done("full_line", 64 * int'(MC));

        // Random backpressure on a 4-char line.
        rdy_rand = 1'b1;
        rand_chars(cq, 4);
        load_line(cq, 1'b1);
        wait_done("backpressure", 256);

        // Clear at pixel 37 of a 2-char line.
        rdy_rand = 1'b0;
        rand_chars(cq, 2);
        load_line(cq, 1'b1);
        k = 0;
        while (line_cnt != 36 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        check("clear_reach", 32'(line_cnt), 36);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("after_clear", 32'({px_valid, busy, load_ready}), 32'b001);
        cq.delete(); cq.push_back(5'($urandom_range(0, 30)));
        load_line(cq, 1'b1);
        wait_done("after_clear_line", 64);

        // Asynchronous reset mid-render.
        rand_chars(cq, 3);
        load_line(cq, 1'b1);
        k = 0;
        while (line_cnt < 50 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_flags", 32'({load_ready, px_valid, px_eol, px_eof, busy}), 32'b10000);
        check("async_rst_rom", 32'({rom_char, rom_row, rom_col}), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("no_px_after_rst", 32'({px_valid, busy, px_eol, px_eof}), 0);
        end

        // Random lines with random backpressure.
        rdy_rand = 1'b1;
        for (int t = 0; t < 3; t++) begin
            int n;
            n = int'($urandom_range(1, MC));
            rand_chars(cq, n);
            load_line(cq, 1'b1);
            wait_done($sformatf("rand%0d", t), 64 * n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/text_render_seq.md
TEXT_RENDER_SEQ -- requirements
Module: text_render_seq

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 16, meaning line-buffer depth in characters (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port clear  input  1  synchronous abort; returns the block to IDLE.
REQ-005 SHALL have port load_valid  input  1  character load request.
REQ-006 SHALL have port load_ready  output  1  block accepts a character this cycle.
REQ-007 SHALL have port load_char  input  5  glyph code (ROM char index 0..30).
REQ-008 SHALL have port load_last  input  1  marks the final character of the line.
REQ-009 SHALL have port rom_char  output  5  glyph-ROM char address.
REQ-010 SHALL have port rom_row  output  3  glyph-ROM row address.
REQ-011 SHALL have port rom_col  output  3  glyph-ROM column address.
REQ-012 SHALL have port rom_dot  input  1  combinational glyph-ROM pixel for the current address.
REQ-013 SHALL have port px_valid  output  1  pixel available.
REQ-014 SHALL have port px_ready  input  1  downstream accepts the pixel.
REQ-015 SHALL have port px_dot  output  1  pixel value.
REQ-016 SHALL have port px_eol  output  1  pixel is the last of a scan row (last char, col 7).
REQ-017 SHALL have port px_eof  output  1  pixel is the last of the line (row 7, last char, col 7).
REQ-018 SHALL have port busy  output  1  high in LOAD or RENDER.

Function
REQ-019 SHALL implement states IDLE, LOAD, RENDER.
REQ-020 IDLE: load_ready=1 and px_valid=0; a handshake (load_valid&&load_ready) writes load_char to buffer[0], sets wr_ptr=1, and goes to LOAD, or to RENDER if load_last=1 (length 1).
REQ-021 LOAD: load_ready=1; each handshake writes buffer[wr_ptr] and increments wr_ptr.
REQ-022 LOAD SHALL go to RENDER on a handshake with load_last=1, or on the handshake that writes index MAX_CHARS-1 (forced last, regardless of load_last).
REQ-023 On entry to RENDER: length=number of stored chars (1..MAX_CHARS); row, char index ci and col all 0.
REQ-024 RENDER: load_ready=0; rom_char=buffer[ci], rom_row=row, rom_col=col; px_valid=1; px_dot=rom_dot (same cycle, zero latency).
REQ-025 Outside RENDER, rom_char, rom_row and rom_col SHALL be 0.
REQ-026 Scan order SHALL be row-major: col 0..7 within each char, then ci 0..length-1, then row 0..7.
REQ-027 On px_valid&&px_ready the position SHALL advance one step: col+1; at col=7, col=0 and ci+1; at ci=length-1, ci=0 and row+1.
REQ-028 Without px_ready, all outputs SHALL hold stable (no advance, no drop).
REQ-029 px_eol SHALL equal (ci==length-1 && col==7); px_eof SHALL equal px_eol && row==7; both are 0 outside RENDER.
REQ-030 The handshake on a px_eof pixel SHALL return the block to IDLE in the next cycle.
REQ-031 A line SHALL emit exactly 64*length pixels.
REQ-032 clear=1 SHALL take priority over any handshake that cycle and go to IDLE next cycle; buffer contents need not be cleared; wr_ptr, ci, row and col are zeroed.
REQ-033 busy SHALL be (state!=IDLE).

Reset
REQ-034 While rst_n=0: state=IDLE; wr_ptr, length, ci, row and col=0; load_ready=1; px_valid, px_eol, px_eof and busy=0; rom_* =0. Buffer contents are don't-care.
REQ-035 Reset mid-LOAD or mid-RENDER SHALL abandon the line; no pixel is emitted after rst_n rises until a new line is loaded.

Verification
REQ-036 Load char 1 with last=1, px_ready=1 -> 64 pixels; row 0 px_dot = 0,0,0,1,0,0,0,0; px_eol pulses every 8th pixel; px_eof on pixel 64; IDLE one cycle after.
REQ-037 Load chars 2,5,10 (last on 10) -> length 3; rom_char sequence for row 0 is 2x8, 5x8, 10x8; px_eol on pixels 24, 48 ... 192; px_eof only on pixel 192.
REQ-038 Load MAX_CHARS+1 chars with load_last=0 -> RENDER after char MAX_CHARS; load_ready=0 during the extra attempt; 64*MAX_CHARS pixels emitted.
REQ-039 Random px_ready (50%) on a 4-char line -> output sequence identical to px_ready=1; no pixel changes while px_valid&&!px_ready.
REQ-040 Assert clear at pixel 37 of a 2-char line -> px_valid=0 next cycle, state IDLE, load_ready=1; a new 1-char load renders correctly from row 0, col 0.
REQ-041 Drop rst_n mid-RENDER -> outputs take the REQ-034 values immediately (asynchronously), and no pixel is emitted after release.
